mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LAT, default 2, memory access latency in cycles; legal range 1..8.
REQ-002 Parameter: AW, default 32, address width.
REQ-003 Parameter: DW, default 32, data width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 req0/req1  in  1  access request from core (0) and loader/debug port (1).
REQ-007 we0/we1  in  1  1 = write, 0 = read, per requester.
REQ-008 addr0/addr1  in  AW  byte address per requester.
REQ-009 wdata0/wdata1  in  DW  write data per requester.
REQ-010 gnt0/gnt1  out  1  high for every cycle the requester owns memory.
REQ-011 done0/done1  out  1  single-cycle completion pulse.
REQ-012 rdata0/rdata1  out  DW  read data; valid only while the matching done is high.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_addr  out  AW  memory address.
REQ-015 mem_wdata  out  DW  memory write data.
REQ-016 mem_rdata  in  DW  memory read data, valid LAT cycles after address is first presented.
REQ-017 busy  out  1  high in any BUSY state.

Function
REQ-018 States: IDLE, BUSY0, BUSY1; a down-counter cnt of 4 bits; a last-grant pointer lg.
REQ-019 Requester protocol: hold req, we, addr, wdata stable until done; a req still high in the cycle after done is a new request.
REQ-020 IDLE, one req high: next cycle enter that requester's BUSY state.
REQ-021 IDLE, both req high: grant the requester not equal to lg; lg updates to the granted index on every grant.
REQ-022 On BUSY entry: capture we, addr, wdata of the winner into internal registers; load cnt = LAT.
REQ-023 In BUSY: mem_addr and mem_wdata come from the captured registers; the matching gnt is high; cnt decrements each cycle.
REQ-024 mem_we high only in the first BUSY cycle (cnt == LAT) of a captured write; 0 otherwise.
REQ-025 done pulses in the BUSY cycle where cnt == 1; rdata of that requester = mem_rdata combinationally in that cycle; rdata is 0 when done is low.
REQ-026 Writes also complete with a done pulse after LAT cycles; rdata is don't-care for writes.
REQ-027 Latency: req first sampled in IDLE at edge N gives done in cycle N+LAT (LAT=1: done and mem_we in the same single BUSY cycle).
REQ-028 Done cycle transition: if the other requester's req is high, go directly to its BUSY state (capture, cnt = LAT, lg update); otherwise go to IDLE.
REQ-029 The completing requester's own req in its done cycle is ignored for arbitration; this guarantees alternation under continuous contention.
REQ-030 In IDLE: gnt0 = gnt1 = done0 = done1 = mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0.
REQ-031 gnt0 and gnt1 are never high together; done0 and done1 are never high together.

Reset
REQ-032 reset low at a clock edge: state = IDLE, cnt = 0, lg = 1 (core wins first contention), capture registers = 0.
REQ-033 Reset mid-access abandons the access: no done is issued, mem_we drops at the next edge, and any pending request is re-arbitrated only after reset releases.
REQ-034 Reset has priority over every other event in the same cycle.

Verification
REQ-035 Single read, LAT=2: req0=1, we0=0, addr0=0x100 at cycle 0 -> gnt0 high in cycles 1-2, mem_addr=0x100, done0 in cycle 2 with rdata0 = mem_rdata; IDLE in cycle 3.
REQ-036 Single write, LAT=2: req1=1, we1=1, addr1=0x40, wdata1=0xDEADBEEF -> mem_we=1 only in cycle 1, mem_wdata=0xDEADBEEF, done1 in cycle 2.
REQ-037 Simultaneous requests after reset: req0=req1=1 at cycle 0 -> BUSY0 in cycles 1-2, BUSY1 in cycles 3-4 with no IDLE gap; done0 in cycle 2, done1 in cycle 4.
REQ-038 Continuous contention over 8 accesses -> grants strictly alternate 0,1,0,1...; gnt0 and gnt1 are never high together.
REQ-039 LAT=1 vs LAT=8 with a single read -> done in cycle 1 or cycle 8 respectively; mem_we never high for reads.
REQ-040 Reset low in cycle 1 of a BUSY1 write -> no done1, all outputs 0 in the next cycle, lg = 1, and re-arbitration starts after reset releases.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
//   slave  : arbiter side (takes requests and mem_rdata, drives grants, completions, memory bus)
//   master : environment side (requesters and memory model)
// Signals: req/we/addr/wdata per requester in, gnt/done/rdata per requester out,
//          mem_we/mem_addr/mem_wdata to memory, mem_rdata from memory, busy status.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: core (0) and loader/debug (1) share one memory with a fixed
// access latency LAT. Round-robin on contention via a last-grant pointer; each access
// holds the bus for LAT cycles and ends with a one-cycle done pulse.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   bus   : mem_arbiter_if slave modport (requests, grants, completions, memory bus)
module mem_arbiter #(
    parameter int unsigned LAT = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

    localparam logic [3:0] CntInit = 4'(LAT);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          lg_q, lg_d;
    logic          cap_we_q, cap_we_d;
    logic [AW-1:0] cap_addr_q, cap_addr_d;
    logic [DW-1:0] cap_wdata_q, cap_wdata_d;

    logic start;
    logic win;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lg_d        = lg_q;
        cap_we_d    = cap_we_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        start       = 1'b0;
        win         = 1'b0;

        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        bus.done0     = 1'b0;
        bus.done1     = 1'b0;
        bus.rdata0    = '0;
        bus.rdata1    = '0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = 1'b0;

        if (state_q != StIdle) begin
            bus.busy      = 1'b1;
            bus.mem_addr  = cap_addr_q;
            bus.mem_wdata = cap_wdata_q;
            bus.mem_we    = cap_we_q && (cnt_q == CntInit);
            cnt_d         = cnt_q - 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.req0 && bus.req1) begin
                    start = 1'b1;
                    win   = ~lg_q;
                end else if (bus.req0) begin
                    start = 1'b1;
                    win   = 1'b0;
                end else if (bus.req1) begin
                    start = 1'b1;
                    win   = 1'b1;
                end
            end
            StBusy0: begin
                bus.gnt0 = 1'b1;
                if (cnt_q == 4'd1) begin
                    bus.done0  = 1'b1;
                    bus.rdata0 = bus.mem_rdata;
                    // Own req is ignored here so contention strictly alternates.
                    if (bus.req1) begin
                        start = 1'b1;
                        win   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StBusy1: begin
                bus.gnt1 = 1'b1;
                if (cnt_q == 4'd1) begin
                    bus.done1  = 1'b1;
                    bus.rdata1 = bus.mem_rdata;
                    if (bus.req0) begin
                        start = 1'b1;
                        win   = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d     = win ? StBusy1 : StBusy0;
            cnt_d       = CntInit;
            lg_d        = win;
            cap_we_d    = win ? bus.we1 : bus.we0;
            cap_addr_d  = win ? bus.addr1 : bus.addr0;
            cap_wdata_d = win ? bus.wdata1 : bus.wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            lg_q        <= 1'b1;
            cap_we_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lg_q        <= lg_d;
            cap_we_q    <= cap_we_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model (owner + cycles elapsed) against
// a LAT=2 instance under directed and random traffic, plus LAT=1 / LAT=8 latency checks.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus8 ();

    mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    mem_arbiter #(.LAT(1),   .AW(AW), .DW(DW)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_arbiter #(.LAT(8),   .AW(AW), .DW(DW)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    // Requester / memory stimulus for the LAT=2 instance.
    logic          r_req[2];
    logic          r_we[2];
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wdata[2];
    logic [DW-1:0] r_rdata;

    assign bus2.req0      = r_req[0];
    assign bus2.req1      = r_req[1];
    assign bus2.we0       = r_we[0];
    assign bus2.we1       = r_we[1];
    assign bus2.addr0     = r_addr[0];
    assign bus2.addr1     = r_addr[1];
    assign bus2.wdata0    = r_wdata[0];
    assign bus2.wdata1    = r_wdata[1];
    assign bus2.mem_rdata = r_rdata;

    // Reference model: who owns memory, how many cycles it has held it, captured request.
    int            m_owner;
    int            m_age;
    int            m_lg;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    int last_done;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_txn(input int i);
        r_req[i]   = 1'b1;
        r_we[i]    = 1'($urandom_range(0, 1));
        r_addr[i]  = $urandom;
        r_wdata[i] = $urandom;
    endtask

    // mode 0: directed, drop req after done; 1: random traffic; 2: continuous contention
    task automatic cycle_check(input int mode);
        logic          e_gnt[2];
        logic          e_done[2];
        logic [DW-1:0] e_rd[2];
        logic          e_we;
        logic          e_busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        int            n_owner, n_age, n_lg, w, who;
        logic          n_we;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_wdata;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e_gnt[i]  = (m_owner == i);
            e_done[i] = (m_owner == i) && (m_age == LAT);
            e_rd[i]   = e_done[i] ? r_rdata : '0;
        end
        e_busy  = (m_owner >= 0);
        e_we    = e_busy && m_we && (m_age == 1);
        e_addr  = e_busy ? m_addr : '0;
        e_wdata = e_busy ? m_wdata : '0;

        check_val("gnt0", bus2.gnt0, e_gnt[0]);
        check_val("gnt1", bus2.gnt1, e_gnt[1]);
        check_val("done0", bus2.done0, e_done[0]);
        check_val("done1", bus2.done1, e_done[1]);
        check_val("rdata0", bus2.rdata0, e_rd[0]);
        check_val("rdata1", bus2.rdata1, e_rd[1]);
        check_val("mem_we", bus2.mem_we, e_we);
        check_val("mem_addr", bus2.mem_addr, e_addr);
        check_val("mem_wdata", bus2.mem_wdata, e_wdata);
        check_val("busy", bus2.busy, e_busy);
        check_val("gnt_excl", bus2.gnt0 & bus2.gnt1, 1'b0);
        check_val("done_excl", bus2.done0 & bus2.done1, 1'b0);

        if (mode == 2 && (bus2.done0 || bus2.done1)) begin
            who = bus2.done1 ? 1 : 0;
            if (last_done >= 0) check_val("alternate", who, 1 - last_done);
            last_done = who;
        end

        n_owner = m_owner;
        n_age   = m_age;
        n_lg    = m_lg;
        n_we    = m_we;
        n_addr  = m_addr;
        n_wdata = m_wdata;
        w       = -1;
        if (!reset) begin
            n_owner = -1;
            n_age   = 0;
            n_lg    = 1;
            n_we    = 1'b0;
            n_addr  = '0;
            n_wdata = '0;
        end else if (m_owner < 0) begin
            if (r_req[0] && r_req[1]) w = (m_lg == 0) ? 1 : 0;
            else if (r_req[0])        w = 0;
            else if (r_req[1])        w = 1;
        end else if (m_age == LAT) begin
            if (r_req[1 - m_owner]) w = 1 - m_owner;
            else                    n_owner = -1;
        end else begin
            n_age = m_age + 1;
        end
        if (w >= 0) begin
            n_owner = w;
            n_age   = 1;
            n_lg    = w;
            n_we    = r_we[w];
            n_addr  = r_addr[w];
            n_wdata = r_wdata[w];
        end

        @(posedge clk);
        #1;
        m_owner = n_owner;
        m_age   = n_age;
        m_lg    = n_lg;
        m_we    = n_we;
        m_addr  = n_addr;
        m_wdata = n_wdata;
        r_rdata = $urandom;

        for (int i = 0; i < 2; i++) begin
            if (e_done[i]) begin
                if (mode == 0) r_req[i] = 1'b0;
                else if (mode == 2) new_txn(i);
                else if ($urandom_range(0, 1) == 1) new_txn(i);
                else r_req[i] = 1'b0;
            end else if (!r_req[i]) begin
                if (mode == 2) new_txn(i);
                else if (mode == 1 && $urandom_range(0, 2) == 0) new_txn(i);
            end
        end
    endtask

    task automatic run(input int n, input int mode);
        for (int k = 0; k < n; k++) cycle_check(mode);
    endtask

    initial begin
        int d1, d8;

        m_owner   = -1;
        m_age     = 0;
        m_lg      = 1;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        last_done = -1;
        for (int i = 0; i < 2; i++) begin
            r_req[i]   = 1'b0;
            r_we[i]    = 1'b0;
            r_addr[i]  = '0;
            r_wdata[i] = '0;
        end
        r_rdata = 32'h0BAD_F00D;
        bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.we0 = 1'b0; bus1.we1 = 1'b0;
        bus1.addr0 = '0; bus1.addr1 = '0; bus1.wdata0 = '0; bus1.wdata1 = '0;
        bus1.mem_rdata = '0;
        bus8.req0 = 1'b0; bus8.req1 = 1'b0; bus8.we0 = 1'b0; bus8.we1 = 1'b0;
        bus8.addr0 = '0; bus8.addr1 = '0; bus8.wdata0 = '0; bus8.wdata1 = '0;
        bus8.mem_rdata = '0;

        // Reset state
        reset = 1'b0;
        run(2, 0);
        reset = 1'b1;

        // LAT=1 and LAT=8 single reads, run side by side while the LAT=2 port stays idle
        bus1.req0 = 1'b1; bus1.addr0 = 32'h80; bus1.mem_rdata = 32'hA5A5_0001;
        bus8.req0 = 1'b1; bus8.addr0 = 32'h84; bus8.mem_rdata = 32'hA5A5_0008;
        d1 = -1;
        d8 = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus1.done0 && d1 < 0) begin
                d1 = k;
                check_val("lat1_rdata", bus1.rdata0, 32'hA5A5_0001);
            end
            if (bus8.done0 && d8 < 0) begin
                d8 = k;
                check_val("lat8_rdata", bus8.rdata0, 32'hA5A5_0008);
            end
            check_val("lat1_no_we", bus1.mem_we, 1'b0);
            check_val("lat8_no_we", bus8.mem_we, 1'b0);
            @(posedge clk);
            #1;
            if (d1 == k) bus1.req0 = 1'b0;
            if (d8 == k) bus8.req0 = 1'b0;
        end
        check_val("lat1_done_cycle", d1, 1);
        check_val("lat8_done_cycle", d8, 8);

        // Single read on the core port
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h100; r_wdata[0] = '0;
        run(5, 0);

        // Single write on the loader port
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 32'h40; r_wdata[1] = 32'hDEAD_BEEF;
        run(5, 0);

        // Simultaneous requests after reset: core first, loader back to back
        reset = 1'b0;
        run(1, 0);
        reset = 1'b1;
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h200;
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 32'h300;
        run(7, 0);

        // Continuous contention
        last_done = -1;
        new_txn(0);
        new_txn(1);
        run(20, 2);
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        run(4, 0);

        // Reset in the first cycle of a loader write, then re-arbitration with both requesting
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 32'h44; r_wdata[1] = 32'h1234_5678;
        run(1, 0);
        reset = 1'b0;
        run(1, 0);
        reset = 1'b1;
        run(1, 0);
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h48;
        run(8, 0);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 39) != 0);
            cycle_check(1);
        end
        reset = 1'b1;
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        run(4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
